// File: rtl/memory_arbiter.sv
// memory_arbiter: four-client request/grant arbiter in front of memory_controller.
// Grants one client per transaction, drives the controller port select (mc_state),
// enable and the per-port read/write strobes, then pulses ack to the winner.
// Transaction period is ACCESS_CYCLES+2: ACCESS_CYCLES strobe cycles, one ack
// cycle, one idle cycle.
//
// Parameters:
//   ACCESS_CYCLES  strobe hold time per access, 1..15 (default 2)
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   req[3:0]       per-client level request
//   we[3:0]        per-client direction (1 = write), sampled at grant
//   gnt[3:0]       one-hot registered grant, held through ack
//   ack[3:0]       one-cycle completion pulse
//   mc_state[1:0]  controller port select, held after the access
//   mc_en          controller enable, high while strobing
//   mc_read[3:0]   controller read0..3 strobes
//   mc_write[3:0]  controller write0..3 strobes
// Build option:
//   MEM_ARB_FIXED_PRIORITY_EN  fixed priority (client 0 highest) instead of
//                              round-robin.

// One client lane: registers that client's grant, ack and strobes.
module memory_arbiter_lane (
  input  logic clk,
  input  logic reset,
  input  logic sel,        // this lane is the winner for the next cycle
  input  logic nxt_busy,   // next state is GRANT or ACK
  input  logic nxt_grant,  // next state is GRANT
  input  logic nxt_ack,    // next state is ACK
  input  logic dir,        // latched direction of the winner for the next cycle
  output logic gnt,
  output logic ack,
  output logic rd,
  output logic wr
);
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt <= 1'b0;
      ack <= 1'b0;
      rd  <= 1'b0;
      wr  <= 1'b0;
    end else begin
      gnt <= sel & nxt_busy;
      ack <= sel & nxt_ack;
      rd  <= sel & nxt_grant & ~dir;
      wr  <= sel & nxt_grant & dir;
    end
  end
endmodule

module memory_arbiter #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [3:0] we,
  output logic [3:0] gnt,
  output logic [3:0] ack,
  output logic [1:0] mc_state,
  output logic       mc_en,
  output logic [3:0] mc_read,
  output logic [3:0] mc_write
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;

  state_t     state, nxt_state;
  logic [3:0] cnt, nxt_cnt;
  logic [1:0] nxt_win;
  logic       dir, nxt_dir;

`ifdef MEM_ARB_FIXED_PRIORITY_EN
  function automatic logic [1:0] pick(input logic [3:0] r);
    pick = 2'd0;
    for (int i = NUM_LANES - 1; i >= 0; i--)
      if (r[i]) pick = 2'(i);
  endfunction
`else
  logic [1:0] last, nxt_last;

  // Search starts one past the previous winner; 2-bit add wraps mod 4.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] l);
    logic [1:0] idx;
    logic       found;
    pick  = 2'd0;
    found = 1'b0;
    for (int o = 1; o <= NUM_LANES; o++) begin
      idx = l + 2'(o);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      dir      <= 1'b0;
      mc_state <= 2'd0;
      mc_en    <= 1'b0;
    end else begin
      state    <= nxt_state;
      cnt      <= nxt_cnt;
      dir      <= nxt_dir;
      mc_state <= nxt_win;
      mc_en    <= (nxt_state == GRANT);
    end
  end

`ifndef MEM_ARB_FIXED_PRIORITY_EN
  always_ff @(posedge clk) begin
    if (reset) last <= 2'd3;
    else       last <= nxt_last;
  end
`endif

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_win   = mc_state;   // mc_state doubles as the latched winner index
    nxt_dir   = dir;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
    nxt_last  = last;
`endif
    case (state)
      IDLE: begin
        nxt_cnt = 4'd0;
        if (|req) begin
          nxt_state = GRANT;
`ifdef MEM_ARB_FIXED_PRIORITY_EN
          nxt_win   = pick(req);
`else
          nxt_win   = pick(req, last);
          nxt_last  = nxt_win;
`endif
          nxt_dir   = we[nxt_win];
        end
      end
      GRANT: begin
        nxt_cnt = cnt + 4'd1;
        if (cnt == 4'(ACCESS_CYCLES - 1)) nxt_state = ACK;
      end
      ACK: begin
        nxt_state = IDLE;
        nxt_cnt   = 4'd0;
      end
      default: begin
        nxt_state = IDLE;
        nxt_cnt   = 4'd0;
      end
    endcase
  end

  logic nxt_busy, nxt_grant, nxt_ack;
  assign nxt_grant = (nxt_state == GRANT);
  assign nxt_ack   = (nxt_state == ACK);
  assign nxt_busy  = nxt_grant | nxt_ack;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    memory_arbiter_lane u_lane (
      .clk       (clk),
      .reset     (reset),
      .sel       (nxt_win == 2'(g)),
      .nxt_busy  (nxt_busy),
      .nxt_grant (nxt_grant),
      .nxt_ack   (nxt_ack),
      .dir       (nxt_dir),
      .gnt       (gnt[g]),
      .ack       (ack[g]),
      .rd        (mc_read[g]),
      .wr        (mc_write[g])
    );
  end
endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;
  localparam int AC = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req, we;
  logic [3:0] gnt, ack, mc_read, mc_write;
  logic [1:0] mc_state;
  logic       mc_en;

  memory_arbiter #(.ACCESS_CYCLES(AC)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .gnt(gnt), .ack(ack),
    .mc_state(mc_state), .mc_en(mc_en), .mc_read(mc_read), .mc_write(mc_write)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] gnt;
    logic [3:0] ack;
    logic [1:0] st;
    logic       en;
    logic [3:0] rd;
    logic [3:0] wr;
  } out_t;

  typedef struct packed {
    logic       rst;
    logic [3:0] req;
    logic [3:0] we;
    out_t       exp;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic out_t cur();
    cur = '{gnt: gnt, ack: ack, st: mc_state, en: mc_en, rd: mc_read, wr: mc_write};
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got gnt=%b ack=%b st=%0d en=%b rd=%b wr=%b, want gnt=%b ack=%b st=%0d en=%b rd=%b wr=%b",
               name, act.gnt, act.ack, act.st, act.en, act.rd, act.wr,
               exp.gnt, exp.ack, exp.st, exp.en, exp.rd, exp.wr);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Drive inputs, let one rising edge pass, return at the following negedge.
  task automatic apply(input logic r, input logic [3:0] rq, input logic [3:0] w);
    reset = r;
    req   = rq;
    we    = w;
    @(negedge clk);
  endtask

  // ---------------- transaction-level reference model ----------------
  out_t       mq[$];   // expected outputs for upcoming cycles of the current transaction
  logic [1:0] m_last;
  logic [1:0] m_st;

  function automatic logic [1:0] m_pick(input logic [3:0] r, input logic [1:0] l);
`ifdef MEM_ARB_FIXED_PRIORITY_EN
    for (int i = 0; i < 4; i++) if (r[i]) return 2'(i);
`else
    for (int o = 1; o <= 4; o++) if (r[(l + o) % 4]) return 2'((l + o) % 4);
`endif
    return 2'd0;
  endfunction

  task automatic model_step(input logic r, input logic [3:0] rq, input logic [3:0] w,
                            output out_t e);
    logic [1:0] win;
    logic [3:0] oh;
    if (r) begin
      mq.delete();
      m_last = 2'd3;
      m_st   = 2'd0;
    end else if (mq.size() == 0 && rq != 4'd0) begin
      win    = m_pick(rq, m_last);
      oh     = 4'b0001 << win;
      m_last = win;
      m_st   = win;
      for (int i = 0; i < AC; i++)
        mq.push_back('{gnt: oh, ack: 4'd0, st: win, en: 1'b1,
                       rd: w[win] ? 4'd0 : oh, wr: w[win] ? oh : 4'd0});
      mq.push_back('{gnt: oh, ack: oh, st: win, en: 1'b0, rd: 4'd0, wr: 4'd0});
      mq.push_back('{gnt: 4'd0, ack: 4'd0, st: win, en: 1'b0, rd: 4'd0, wr: 4'd0});
    end
    if (mq.size() > 0) e = mq.pop_front();
    else e = '{gnt: 4'd0, ack: 4'd0, st: m_st, en: 1'b0, rd: 4'd0, wr: 4'd0};
  endtask

  function automatic int popc(input logic [3:0] v);
    return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
  endfunction

  vec_t vt[$];

  initial begin
    reset = 1'b1; req = 4'd0; we = 4'd0;
    @(negedge clk);

    // ---------------- directed table ----------------
    // fields: rst, req, we, {gnt, ack, st, en, rd, wr}
    vt.push_back('{1'b1, 4'b0000, 4'b0000, '{4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000}});
    // single write from client 0
    vt.push_back('{1'b0, 4'b0001, 4'b0001, '{4'b0001, 4'b0000, 2'd0, 1'b1, 4'b0000, 4'b0001}});
    vt.push_back('{1'b0, 4'b0001, 4'b0001, '{4'b0001, 4'b0000, 2'd0, 1'b1, 4'b0000, 4'b0001}});
    vt.push_back('{1'b0, 4'b0000, 4'b0000, '{4'b0001, 4'b0001, 2'd0, 1'b0, 4'b0000, 4'b0000}});
    vt.push_back('{1'b0, 4'b0000, 4'b0000, '{4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000}});
    vt.push_back('{1'b0, 4'b0000, 4'b0000, '{4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000}});
    // read from client 2, we toggled mid-grant has no effect
    vt.push_back('{1'b0, 4'b0100, 4'b0000, '{4'b0100, 4'b0000, 2'd2, 1'b1, 4'b0100, 4'b0000}});
    vt.push_back('{1'b0, 4'b0100, 4'b0100, '{4'b0100, 4'b0000, 2'd2, 1'b1, 4'b0100, 4'b0000}});
    vt.push_back('{1'b0, 4'b0000, 4'b1111, '{4'b0100, 4'b0100, 2'd2, 1'b0, 4'b0000, 4'b0000}});
    vt.push_back('{1'b0, 4'b0000, 4'b0000, '{4'b0000, 4'b0000, 2'd2, 1'b0, 4'b0000, 4'b0000}});
    // client 1 granted, reset during its second grant cycle aborts it
    vt.push_back('{1'b0, 4'b0010, 4'b0010, '{4'b0010, 4'b0000, 2'd1, 1'b1, 4'b0000, 4'b0010}});
    vt.push_back('{1'b1, 4'b0010, 4'b0010, '{4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000}});
    // all request after reset: client 0 wins again, no ack from the aborted access
    vt.push_back('{1'b0, 4'b1111, 4'b0000, '{4'b0001, 4'b0000, 2'd0, 1'b1, 4'b0001, 4'b0000}});
    vt.push_back('{1'b0, 4'b1111, 4'b0000, '{4'b0001, 4'b0000, 2'd0, 1'b1, 4'b0001, 4'b0000}});
    vt.push_back('{1'b0, 4'b0000, 4'b0000, '{4'b0001, 4'b0001, 2'd0, 1'b0, 4'b0000, 4'b0000}});
    vt.push_back('{1'b0, 4'b0000, 4'b0000, '{4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000}});
    // client 1 read, req dropped after first grant cycle still completes
    vt.push_back('{1'b0, 4'b0010, 4'b0000, '{4'b0010, 4'b0000, 2'd1, 1'b1, 4'b0010, 4'b0000}});
    vt.push_back('{1'b0, 4'b0000, 4'b0000, '{4'b0010, 4'b0000, 2'd1, 1'b1, 4'b0010, 4'b0000}});
    vt.push_back('{1'b0, 4'b0000, 4'b0000, '{4'b0010, 4'b0010, 2'd1, 1'b0, 4'b0000, 4'b0000}});
    vt.push_back('{1'b0, 4'b0000, 4'b0000, '{4'b0000, 4'b0000, 2'd1, 1'b0, 4'b0000, 4'b0000}});

    for (int i = 0; i < vt.size(); i++) begin
      apply(vt[i].rst, vt[i].req, vt[i].we);
      check($sformatf("vec%0d", i), cur(), vt[i].exp);
    end

    // ---------------- rotation with all clients requesting ----------------
    begin
      logic [3:0] rq;
      int order[4];
      int t_ack[4];
      int n = 0;
      apply(1'b1, 4'd0, 4'd0);
      rq = 4'b1111;
      for (int c = 1; c <= 40 && n < 4; c++) begin
        apply(1'b0, rq, 4'b0101);
        if (ack != 4'd0) begin
          order[n] = 0;
          for (int b = 0; b < 4; b++) if (ack[b]) order[n] = b;
          t_ack[n] = c;
          rq = rq & ~ack;   // client drops req the cycle after its ack
          n++;
        end
      end
      check_int("rot_count", n, 4);
      for (int i = 0; i < n; i++) check_int($sformatf("rot_order%0d", i), order[i], i);
      for (int i = 1; i < n; i++) check_int($sformatf("rot_gap%0d", i), t_ack[i] - t_ack[i-1], AC + 2);
    end

    // ---------------- clients 0 and 3 held requesting ----------------
    begin
      int a0 = 0;
      int a3 = 0;
      apply(1'b1, 4'd0, 4'd0);
      for (int c = 0; c < 6 * (AC + 2); c++) begin
        apply(1'b0, 4'b1001, 4'b0000);
        if (ack[0]) a0++;
        if (ack[3]) a3++;
      end
`ifdef MEM_ARB_FIXED_PRIORITY_EN
      check_int("fixed_c0_acks", a0, 6);
      check_int("fixed_c3_acks", a3, 0);
`else
      check_int("rr_c0_acks", a0, 3);
      check_int("rr_c3_acks", a3, 3);
`endif
    end

    // ---------------- randomized against the reference model ----------------
    begin
      out_t e;
      logic       r;
      logic [3:0] rq, w;
      apply(1'b1, 4'd0, 4'd0);
      model_step(1'b1, 4'd0, 4'd0, e);
      for (int c = 0; c < 800; c++) begin
        r  = ($urandom_range(0, 59) == 0);
        rq = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
        w  = 4'($urandom);
        apply(r, rq, w);
        model_step(r, rq, w, e);
        check($sformatf("rand%0d", c), cur(), e);
        if (popc(gnt) > 1 || popc(ack) > 1 || popc(mc_read) > 1 || popc(mc_write) > 1 ||
            (mc_read & mc_write) != 4'd0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL onehot%0d: got gnt=%b ack=%b rd=%b wr=%b, want at most one bit each, rd&wr=0",
                   c, gnt, ack, mc_read, mc_write);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
